// File: rtl/fir_pkg.sv
// Shared constants for the 32-tap FIR filter and its output decimator.
// Also holds the rounding/saturation helper used by the decimator datapath.
package fir_pkg;

  localparam int FIR_TAPS   = 32;
  localparam int FIR_IN_W   = 10;
  localparam int FIR_OUT_W  = 2 * 8 + 1;
  localparam int FIR_SETTLE = FIR_TAPS - 1;

  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_RUN    = 1'b1
  } dec_state_e;

  // Bias added before a right shift by 'shift' bits to round half-up.
  function automatic logic [31:0] fir_round_bias(input int unsigned shift);
    return (shift == 0) ? 32'd0 : (32'd1 << (shift - 1));
  endfunction

  // Shifts a pre-biased value right and clamps it to an unsigned 'width'-bit range.
  // Operands are carried in 32 bits, which covers every filter width in use.
  function automatic logic [31:0] fir_shift_sat(input logic [31:0] value,
                                                input int unsigned shift,
                                                input int unsigned width);
    logic [31:0] shifted;
    logic [31:0] max_val;
    shifted = value >> shift;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (shifted > max_val) ? max_val : shifted;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
// The head is visible on data_o whenever the FIFO is not empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    push_i,
  input  logic [WIDTH-1:0]        data_i,
  input  logic                    pop_i,
  output logic [WIDTH-1:0]        data_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == (AW + 1)'(DEPTH));
  assign level_o = level_q;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // While empty, the last popped word (or zero after reset) is presented.
  assign data_o = empty_o ? hold_q : mem_q[rd_ptr_q];

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    hold_d   = hold_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      hold_d   = mem_q[rd_ptr_q];
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (AW + 1)'(1);
      2'b01:   level_d = level_q - (AW + 1)'(1);
      default: level_d = level_q;
    endcase
  end

  // NOTE: storage has no reset; only pointers and level need one, and empty entries are never shown.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      hold_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      hold_q   <= hold_d;
    end
  end

endmodule

// File: rtl/fir_output_decimator.sv
// Drops the FIR fill-up samples, keeps 1 of DECIM, rounds/scales/saturates
// each kept sample and queues it in a FWFT FIFO for a valid/ready consumer.
module fir_output_decimator
  import fir_pkg::*;
#(
  parameter int IN_W   = FIR_OUT_W,
  parameter int OUT_W  = FIR_IN_W,
  parameter int SHIFT  = 7,
  parameter int DECIM  = 4,
  parameter int SETTLE = FIR_SETTLE,
  parameter int DEPTH  = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [IN_W-1:0]         in_data,
  input  logic                    in_valid,
  output logic [OUT_W-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overflow,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int SET_W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam int PH_W  = (DECIM < 2) ? 1 : $clog2(DECIM);

  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);
  localparam logic [PH_W-1:0]  PHASE_LAST  = PH_W'(DECIM - 1);
  localparam logic [IN_W:0]    ROUND_BIAS  = (IN_W + 1)'(fir_round_bias(SHIFT));
  localparam dec_state_e       START_STATE = (SETTLE == 0) ? ST_RUN : ST_SETTLE;

  dec_state_e       state_q, state_d;
  logic [SET_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic             keep;

  logic             s1_valid_q;
  logic [IN_W:0]    s1_r_q, s1_r_d;
  logic             s2_valid_q;
  logic [OUT_W-1:0] s2_q_q, s2_q_d;

  logic             overflow_q, overflow_d;
  logic             fifo_full;
  logic             fifo_empty;

  // Settle/run control: the sample that completes settling is still discarded.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    phase_d      = phase_q;
    keep         = 1'b0;
    case (state_q)
      ST_SETTLE: begin
        if (in_valid) begin
          settle_cnt_d = settle_cnt_q + SET_W'(1);
          if (settle_cnt_q == SETTLE_LAST) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (in_valid) begin
          keep    = (phase_q == '0);
          phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + PH_W'(1);
        end
      end
      default: state_d = START_STATE;
    endcase
  end

  // One extra bit keeps the rounding add from wrapping at full-scale input.
  assign s1_r_d = {1'b0, in_data} + ROUND_BIAS;
  assign s2_q_d = OUT_W'(fir_shift_sat(32'(s1_r_q), SHIFT, OUT_W));

  // A kept sample meeting a full FIFO with no pop is lost, and that is remembered until reset.
  assign overflow_d = overflow_q | (s2_valid_q & fifo_full & ~out_ready);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= START_STATE;
      settle_cnt_q <= '0;
      phase_q      <= '0;
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      phase_q      <= phase_d;
      s1_valid_q   <= keep;
      s2_valid_q   <= s1_valid_q;
      overflow_q   <= overflow_d;
    end
  end

  // NOTE: datapath registers carry no reset; their valid bits qualify them.
  always_ff @(posedge clock) begin
    s1_r_q <= s1_r_d;
    s2_q_q <= s2_q_d;
  end

  sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (s2_valid_q),
    .data_i  (s2_q_q),
    .pop_i   (out_ready),
    .data_o  (out_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  assign out_valid = ~fifo_empty;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_fir_output_decimator.sv
// Directed bench for fir_output_decimator: one instance with default decimation,
// one with DECIM=1 for rounding, saturation, backpressure and reset cases.
module tb_fir_output_decimator;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [16:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;

  logic [9:0]  a_out_data, b_out_data;
  logic        a_out_valid, b_out_valid;
  logic        a_overflow, b_overflow;
  logic [3:0]  a_level, b_level;

  int total = 0;
  int bad   = 0;

  logic [16:0] stim_q[$];
  logic [9:0]  got_q[$];
  int          max_level;

  always #5 clock = ~clock;

  fir_output_decimator dut_a (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (a_out_data),
    .out_valid (a_out_valid),
    .out_ready (out_ready),
    .overflow  (a_overflow),
    .level     (a_level)
  );

  fir_output_decimator #(.DECIM(1)) dut_b (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (b_out_data),
    .out_valid (b_out_valid),
    .out_ready (out_ready),
    .overflow  (b_overflow),
    .level     (b_level)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic feed(input logic [16:0] d);
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (31) feed(17'd1000);
  endtask

  // Drives queued stimulus one per cycle and records every word popped by the consumer.
  task automatic run(input bit use_b, input int cycles);
    logic       v;
    logic [9:0] d;
    int         lvl;
    for (int i = 0; i < cycles; i++) begin
      if (stim_q.size() > 0) begin
        in_data  = stim_q.pop_front();
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      v   = use_b ? b_out_valid : a_out_valid;
      d   = use_b ? b_out_data : a_out_data;
      lvl = use_b ? int'(b_level) : int'(a_level);
      if (v && out_ready) got_q.push_back(d);
      if (lvl > max_level) max_level = lvl;
      @(negedge clock);
    end
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] got_at(input int i);
    return (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int exp3[5]  = '{1, 2, 0, 0, 1};
    int exp5b[8] = '{2, 3, 4, 5, 6, 7, 8, 10};

    // Reset state and settle discard, first kept sample latency.
    out_ready = 1'b0;
    do_reset();
    check("rst_valid", a_out_valid, 0);
    check("rst_data", a_out_data, 0);
    check("rst_overflow", a_overflow, 0);
    check("rst_level", a_level, 0);
    for (int i = 0; i < 31; i++) begin
      feed(17'd1000);
      check("t1_settle_valid", a_out_valid, 0);
    end
    repeat (3) begin
      @(negedge clock);
      check("t1_idle_valid", a_out_valid, 0);
    end
    feed(17'd192);
    check("t1_lat_c1", a_out_valid, 0);
    @(negedge clock);
    check("t1_lat_c2", a_out_valid, 0);
    @(negedge clock);
    check("t1_lat_c3_valid", a_out_valid, 1);
    check("t1_lat_c3_data", a_out_data, 2);
    check("t1_lat_c3_level", a_level, 1);

    // Decimation by 4 on a ramp with a ready consumer.
    do_reset();
    settle();
    out_ready = 1'b1;
    got_q.delete();
    max_level = 0;
    for (int k = 0; k < 12; k++) stim_q.push_back(17'(128 * k));
    run(1'b0, 18);
    check("t2_count", got_q.size(), 3);
    for (int i = 0; i < 3; i++) check($sformatf("t2_out%0d", i), got_at(i), 4 * i);
    check("t2_max_level", max_level, 1);

    // Rounding with DECIM=1.
    do_reset();
    settle();
    out_ready = 1'b1;
    got_q.delete();
    stim_q = '{17'd191, 17'd192, 17'd0, 17'd63, 17'd64};
    run(1'b1, 10);
    check("t3_count", got_q.size(), 5);
    for (int i = 0; i < 5; i++) check($sformatf("t3_out%0d", i), got_at(i), exp3[i]);

    // Saturation at and near full scale.
    got_q.delete();
    max_level = 0;
    stim_q = '{17'h1FFFF, 17'd130943, 17'd130880};
    run(1'b1, 8);
    check("t4_count", got_q.size(), 3);
    for (int i = 0; i < 3; i++) check($sformatf("t4_out%0d", i), got_at(i), 1023);
    check("t4_overflow", b_overflow, 0);

    // Backpressure: nine kept samples into an eight-deep FIFO.
    do_reset();
    settle();
    out_ready = 1'b0;
    got_q.delete();
    max_level = 0;
    for (int k = 1; k <= 9; k++) stim_q.push_back(17'(128 * k));
    run(1'b1, 14);
    check("t5_level_full", b_level, 8);
    check("t5_max_level", max_level, 8);
    check("t5_overflow_set", b_overflow, 1);
    check("t5_head", b_out_data, 1);
    out_ready = 1'b1;
    run(1'b1, 10);
    check("t5_drain_count", got_q.size(), 8);
    for (int i = 0; i < 8; i++) check($sformatf("t5_drain%0d", i), got_at(i), i + 1);
    check("t5_overflow_sticky", b_overflow, 1);
    check("t5_level_empty", b_level, 0);
    check("t5_valid_empty", b_out_valid, 0);
    check("t5_data_hold", b_out_data, 8);

    // Full FIFO with push and pop in the same cycle.
    do_reset();
    settle();
    out_ready = 1'b0;
    got_q.delete();
    for (int k = 1; k <= 8; k++) stim_q.push_back(17'(128 * k));
    run(1'b1, 12);
    check("t5b_level_full", b_level, 8);
    check("t5b_overflow_pre", b_overflow, 0);
    in_data  = 17'd1280;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    out_ready = 1'b1;
    check("t5b_head_before", b_out_data, 1);
    @(negedge clock);
    out_ready = 1'b0;
    check("t5b_level_hold", b_level, 8);
    check("t5b_no_overflow", b_overflow, 0);
    check("t5b_head_after", b_out_data, 2);
    out_ready = 1'b1;
    run(1'b1, 10);
    check("t5b_drain_count", got_q.size(), 8);
    for (int i = 0; i < 8; i++) check($sformatf("t5b_drain%0d", i), got_at(i), exp5b[i]);

    // Reset mid-operation with queued and in-flight samples.
    do_reset();
    settle();
    out_ready = 1'b0;
    got_q.delete();
    for (int k = 1; k <= 5; k++) stim_q.push_back(17'(128 * k));
    run(1'b1, 8);
    check("t6_level_pre", b_level, 5);
    in_data  = 17'd640;
    in_valid = 1'b1;
    @(negedge clock);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    check("t6_valid_post", b_out_valid, 0);
    check("t6_level_post", b_level, 0);
    check("t6_overflow_post", b_overflow, 0);
    for (int i = 0; i < 31; i++) begin
      feed(17'd5000);
      check("t6_resettle_valid", b_out_valid, 0);
    end
    repeat (3) begin
      @(negedge clock);
      check("t6_idle_valid", b_out_valid, 0);
    end
    feed(17'd192);
    repeat (2) @(negedge clock);
    check("t6_first_valid", b_out_valid, 1);
    check("t6_first_data", b_out_data, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
